// File: rtl/xbar_rr_arbiter_pkg.sv
// Shared types and helpers for the crossbar round-robin input stage.
// Holds the FSM state encoding and the port-index width rule.
package xbar_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // A single requester still needs a 1-bit index so every port vector stays legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbar_rr_pick.sv
// Combinational rotate-priority pick: first set request at or after ptr, wrapping.
// idx is only meaningful while any is high.
module xbar_rr_pick
  import xbar_rr_arbiter_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = idx_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N_PORTS);

  logic [2*N_PORTS-1:0] req_dbl;
  logic [N_PORTS-1:0]   req_rot;
  logic [IDX_W-1:0]     off;
  logic [IDX_W:0]       sum_raw;

  // Rotating the doubled vector puts req[ptr] at bit 0, so a plain
  // lowest-set-bit search gives the round-robin offset.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N_PORTS];

  always_comb begin
    off = '0;
    any = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!any && req_rot[i]) begin
        any = 1'b1;
        off = IDX_W'(i);
      end
    end
  end

  assign sum_raw = {1'b0, ptr} + {1'b0, off};
  assign idx     = (sum_raw >= N_EXT) ? IDX_W'(sum_raw - N_EXT) : IDX_W'(sum_raw);

endmodule

// File: rtl/xbar_rr_arbiter.sv
// Crossbar output-port input stage: round-robin packet arbiter that forwards
// one word per cycle from the granted port into a registered output with strobe.
module xbar_rr_arbiter
  import xbar_rr_arbiter_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int WIDTH   = 32,
  parameter int IDX_W   = idx_width(N_PORTS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_PORTS-1:0]       in_valid,
  input  logic [N_PORTS-1:0]       in_last,
  input  logic [N_PORTS*WIDTH-1:0] in_data,
  output logic [N_PORTS-1:0]       in_ready,
  input  logic                     out_stall,
  output logic                     out_ena,
  output logic [WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]         out_port,
  output logic                     out_last
);

  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(N_PORTS - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic [WIDTH-1:0] port_data [N_PORTS];
  logic [WIDTH-1:0] sel_data;
  logic             sel_valid;
  logic             sel_last;
  logic             xfer;

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
      assign port_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  xbar_rr_pick #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (in_valid),
    .ptr (ptr_reg),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign sel_data  = port_data[grant_reg];
  assign sel_valid = in_valid[grant_reg];
  assign sel_last  = in_last[grant_reg];
  assign xfer      = (state_reg == BUSY) && sel_valid && !out_stall;

  always_comb begin
    in_ready = '0;
    if (state_reg == BUSY) begin
      in_ready[grant_reg] = !out_stall;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          grant_next = pick_idx;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Grant is held until the last beat actually transfers; no timeout.
        if (xfer && sel_last) begin
          state_next = IDLE;
          ptr_next   = (grant_reg == LAST_PORT) ? '0 : grant_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_ena  <= 1'b0;
      out_data <= '0;
      out_port <= '0;
      out_last <= 1'b0;
    end else begin
      out_ena <= xfer;
      if (xfer) begin
        out_data <= sel_data;
        out_port <= grant_reg;
        out_last <= sel_last;
      end
    end
  end

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Self-checking bench for xbar_rr_arbiter: vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_xbar_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_last = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_ready;
  logic           out_stall = 1'b0;
  logic           out_ena;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_port;
  logic           out_last;

  always #5 clock = ~clock;

  xbar_rr_arbiter #(.N_PORTS(N), .WIDTH(W), .IDX_W(IW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_stall (out_stall),
    .out_ena   (out_ena),
    .out_data  (out_data),
    .out_port  (out_port),
    .out_last  (out_last)
  );

  typedef struct packed {
    logic [3:0]  v;
    logic [3:0]  l;
    logic        s;
    logic [31:0] d2;
    logic [3:0]  er;
    logic        ee;
    logic [31:0] ed;
    logic [1:0]  ep;
    logic        el;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc_no = 0;

  // Reference model: arbiter described as "busy with port g" plus round-robin pointer.
  bit          m_busy;
  int          m_grant, m_ptr, m_port;
  bit          m_ena, m_last;
  logic [31:0] m_data;

  int          st_port[$];
  logic [31:0] st_data[$];
  int          st_time[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  task automatic set_word(input int p, input logic [31:0] w);
    in_data[p*W +: W] = w;
  endtask

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_ptr = 0; m_port = 0;
    m_ena = 0; m_last = 0; m_data = '0;
  endtask

  task automatic clear_strobes();
    st_port.delete(); st_data.delete(); st_time.delete();
  endtask

  task automatic model_step();
    bit found;
    if (!m_busy) begin
      m_ena = 0;
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && in_valid[(m_ptr + k) % N]) begin
          m_grant = (m_ptr + k) % N;
          found = 1;
        end
      end
      if (found) m_busy = 1;
    end else begin
      m_ena = in_valid[m_grant] && !out_stall;
      if (m_ena) begin
        m_data = in_data[m_grant*W +: W];
        m_port = m_grant;
        m_last = in_last[m_grant];
        if (m_last) begin
          m_busy = 0;
          m_ptr  = (m_grant + 1) % N;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] er;
    er = '0;
    if (m_busy && !out_stall) er[m_grant] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_ena",  32'(out_ena),  32'(m_ena));
    chk("out_data", out_data,      m_data);
    chk("out_port", 32'(out_port), m_port);
    chk("out_last", 32'(out_last), 32'(m_last));
  endtask

  // Called at the falling edge: compare, log strobe, advance model, move past rising edge.
  task automatic finish_cycle(output logic [N-1:0] hs);
    check_all();
    hs = in_valid & in_ready;
    if (out_ena === 1'b1) begin
      st_port.push_back(int'(out_port));
      st_data.push_back(out_data);
      st_time.push_back(cyc_no);
    end
    model_step();
    cyc_no++;
    @(posedge clock);
    #1;
  endtask

  task automatic cycle(output logic [N-1:0] hs);
    @(negedge clock);
    finish_cycle(hs);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    in_valid = '0; in_last = '0; in_data = '0; out_stall = 1'b0;
    @(negedge clock);
    chk("rst_ena",   32'(out_ena),  32'd0);
    chk("rst_data",  out_data,      32'd0);
    chk("rst_port",  32'(out_port), 32'd0);
    chk("rst_last",  32'(out_last), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    clear_strobes();
  endtask

  initial begin
    vec_t         tbl[7];
    logic [N-1:0] hs;
    int           k;
    int           seq[N], beat[N], len[N], exp_seq[N];

    // Single requester port 2, three beats A/B/C; strobes two cycles after first valid.
    tbl[0] = '{4'b0000, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0};
    tbl[1] = '{4'b0100, 4'b0000, 1'b0, 32'hA, 4'b0000, 1'b0, 32'h0, 2'd0, 1'b0};
    tbl[2] = '{4'b0100, 4'b0000, 1'b0, 32'hA, 4'b0100, 1'b0, 32'h0, 2'd0, 1'b0};
    tbl[3] = '{4'b0100, 4'b0000, 1'b0, 32'hB, 4'b0100, 1'b1, 32'hA, 2'd2, 1'b0};
    tbl[4] = '{4'b0100, 4'b0100, 1'b0, 32'hC, 4'b0100, 1'b1, 32'hB, 2'd2, 1'b0};
    tbl[5] = '{4'b0000, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b1, 32'hC, 2'd2, 1'b1};
    tbl[6] = '{4'b0000, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 32'hC, 2'd2, 1'b1};

    model_reset();
    do_reset();

    for (int i = 0; i < 7; i++) begin
      in_valid  = tbl[i].v;
      in_last   = tbl[i].l;
      out_stall = tbl[i].s;
      set_word(2, tbl[i].d2);
      @(negedge clock);
      chk("tbl_ready", 32'(in_ready), 32'(tbl[i].er));
      chk("tbl_ena",   32'(out_ena),  32'(tbl[i].ee));
      chk("tbl_data",  out_data,      tbl[i].ed);
      chk("tbl_port",  32'(out_port), 32'(tbl[i].ep));
      chk("tbl_last",  32'(out_last), 32'(tbl[i].el));
      finish_cycle(hs);
    end

    // Wrap and skip: pointer now 3, only ports 0 and 3 request.
    clear_strobes();
    in_valid = 4'b1001; in_last = 4'b1001;
    set_word(0, 32'h0000_0C00); set_word(3, 32'h0000_0C03);
    for (int i = 0; i < 4; i++) cycle(hs);
    in_valid = '0;
    for (int i = 0; i < 2; i++) cycle(hs);
    chk("wrap_count", st_port.size(), 2);
    if (st_port.size() >= 2) begin
      chk("wrap_first",  st_port[0], 3);
      chk("wrap_second", st_port[1], 0);
    end

    // Reset mid-packet on port 1, then ports 0 and 1 request: grant must restart from 0.
    in_valid = 4'b0010; in_last = 4'b0000; set_word(1, 32'h111);
    for (int i = 0; i < 3; i++) cycle(hs);
    #2;
    reset = 1'b1;
    #1;
    chk("async_ena",   32'(out_ena),  32'd0);
    chk("async_data",  out_data,      32'd0);
    chk("async_ready", 32'(in_ready), 32'd0);
    chk("async_port",  32'(out_port), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_strobes();
    in_valid = 4'b0011; in_last = 4'b0011;
    set_word(0, 32'hA0); set_word(1, 32'hA1);
    for (int i = 0; i < 3; i++) cycle(hs);
    in_valid = '0;
    for (int i = 0; i < 2; i++) cycle(hs);
    chk("rst_regrant_count", st_port.size(), 1);
    if (st_port.size() >= 1) begin
      chk("rst_regrant_port", st_port[0], 0);
      chk("rst_regrant_data", st_data[0], 32'hA0);
    end

    // Fairness: all ports continuously offer single-beat packets.
    do_reset();
    in_valid = 4'b1111; in_last = 4'b1111;
    for (int p = 0; p < N; p++) set_word(p, 32'hF0 + 32'(p));
    for (int i = 0; i < 11; i++) cycle(hs);
    chk("fair_count", st_port.size(), 5);
    for (int i = 0; i < 5 && i < st_port.size(); i++) begin
      chk("fair_order", st_port[i], i % N);
      if (i > 0) chk("fair_gap", st_time[i] - st_time[i-1], 2);
    end

    // Backpressure mid-packet on port 0: six words, stall three cycles.
    do_reset();
    k = 0;
    for (int c = 0; c < 14; c++) begin
      out_stall   = (c >= 4 && c < 7);
      in_valid[0] = (k < 6);
      in_last[0]  = (k == 5);
      set_word(0, 32'h100 + 32'(k));
      cycle(hs);
      if (hs[0]) k++;
    end
    chk("bp_count", st_data.size(), 6);
    for (int i = 0; i < st_data.size(); i++) chk("bp_word", st_data[i], 32'h100 + 32'(i));

    // Valid gap: granted port 0 pauses two cycles while ports 2 and 3 wait.
    do_reset();
    k = 0;
    for (int c = 0; c < 14; c++) begin
      in_valid    = 4'b1100;
      in_last     = 4'b1100;
      in_valid[0] = (k < 4) && !(c == 3 || c == 4);
      in_last[0]  = (k == 3);
      set_word(0, 32'h200 + 32'(k)); set_word(2, 32'h202); set_word(3, 32'h203);
      cycle(hs);
      if (hs[0]) k++;
    end
    chk("gap_count_ok", 32'(st_port.size() >= 5), 32'd1);
    for (int i = 0; i < 4 && i < st_port.size(); i++) begin
      chk("gap_port", st_port[i], 0);
      chk("gap_word", st_data[i], 32'h200 + 32'(i));
    end
    if (st_port.size() >= 5) chk("gap_next_port", st_port[4], 2);

    // Randomized traffic with per-port sequence numbers for loss/duplication checking.
    do_reset();
    for (int p = 0; p < N; p++) begin
      seq[p] = 0; beat[p] = 0; exp_seq[p] = 0;
      len[p] = int'($urandom_range(1, 4));
    end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) begin
        in_valid[p] = ($urandom_range(0, 9) < 7);
        in_last[p]  = (beat[p] == len[p] - 1);
        set_word(p, {8'(p), 24'(seq[p])});
      end
      out_stall = ($urandom_range(0, 4) == 0);
      cycle(hs);
      for (int p = 0; p < N; p++) begin
        if (hs[p]) begin
          seq[p]++;
          if (beat[p] == len[p] - 1) begin
            beat[p] = 0;
            len[p]  = int'($urandom_range(1, 4));
          end else begin
            beat[p]++;
          end
        end
      end
    end
    in_valid = '0; out_stall = 1'b0;
    for (int i = 0; i < 2; i++) cycle(hs);
    chk("rand_activity", 32'(st_port.size() > 20), 32'd1);
    for (int i = 0; i < st_port.size(); i++) begin
      chk("rand_sb", st_data[i], {8'(st_port[i]), 24'(exp_seq[st_port[i]])});
      exp_seq[st_port[i]]++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
